// File: rtl/morse_rx_decoder.sv
// morse_rx_decoder: measures mark/space durations on a synchronized Morse line and decodes letters to 5-bit codes.
module morse_rx_decoder #(
    parameter int TIME_UNIT = 250000,
    parameter int CNT_W     = 25
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       din,
    output logic [4:0] char_out,
    output logic       char_valid,
    output logic       err,
    output logic       busy
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] MARK  = 2'd1;
    localparam logic [1:0] SPACE = 2'd2;
    localparam logic [CNT_W-1:0] HALF = CNT_W'(TIME_UNIT / 2);
    localparam logic [CNT_W-1:0] LGAP = CNT_W'(2 * TIME_UNIT);
    localparam logic [CNT_W-1:0] WGAP = CNT_W'(5 * TIME_UNIT);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    logic             s1_q, s2_q;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [3:0]       sym_q, sym_d;
    logic [2:0]       sym_cnt_q, sym_cnt_d;
    logic             ovf_q, ovf_d;
    logic             seen_q, seen_d;
    logic [4:0]       char_out_q, char_out_d;
    logic             char_valid_q, char_valid_d;
    logic             err_q, err_d;
    logic [5:0]       dec;

    // Pattern is right-justified with its length, so dash = 1 and the first symbol is the highest used bit.
    always_comb begin
        case ({sym_cnt_q, sym_q})
            7'b001_0000: dec = {1'b1, 5'd5};
            7'b001_0001: dec = {1'b1, 5'd20};
            7'b010_0000: dec = {1'b1, 5'd9};
            7'b010_0001: dec = {1'b1, 5'd1};
            7'b010_0010: dec = {1'b1, 5'd14};
            7'b010_0011: dec = {1'b1, 5'd13};
            7'b011_0000: dec = {1'b1, 5'd19};
            7'b011_0001: dec = {1'b1, 5'd21};
            7'b011_0010: dec = {1'b1, 5'd18};
            7'b011_0011: dec = {1'b1, 5'd23};
            7'b011_0100: dec = {1'b1, 5'd4};
            7'b011_0101: dec = {1'b1, 5'd11};
            7'b011_0110: dec = {1'b1, 5'd7};
            7'b011_0111: dec = {1'b1, 5'd15};
            7'b100_0000: dec = {1'b1, 5'd8};
            7'b100_0001: dec = {1'b1, 5'd22};
            7'b100_0010: dec = {1'b1, 5'd6};
            7'b100_0100: dec = {1'b1, 5'd12};
            7'b100_0110: dec = {1'b1, 5'd16};
            7'b100_0111: dec = {1'b1, 5'd10};
            7'b100_1000: dec = {1'b1, 5'd2};
            7'b100_1001: dec = {1'b1, 5'd24};
            7'b100_1010: dec = {1'b1, 5'd3};
            7'b100_1011: dec = {1'b1, 5'd25};
            7'b100_1100: dec = {1'b1, 5'd26};
            7'b100_1101: dec = {1'b1, 5'd17};
            default:     dec = 6'd0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        cnt_inc      = (cnt_q == WGAP) ? cnt_q : cnt_q + ONE;
        cnt_d        = cnt_inc;
        sym_d        = sym_q;
        sym_cnt_d    = sym_cnt_q;
        ovf_d        = ovf_q;
        seen_d       = seen_q;
        char_out_d   = char_out_q;
        char_valid_d = 1'b0;
        err_d        = 1'b0;
        case (state_q)
            IDLE: begin
                if (s2_q) begin
                    state_d = MARK;
                    cnt_d   = ONE;
                end
            end
            MARK: begin
                if (!s2_q) begin
                    state_d = SPACE;
                    cnt_d   = ONE;
                    if (cnt_q >= HALF) begin
                        if (sym_cnt_q == 3'd4) begin
                            ovf_d = 1'b1;
                        end else begin
                            sym_d     = {sym_q[2:0], cnt_q >= LGAP};
                            sym_cnt_d = sym_cnt_q + 3'd1;
                        end
                    end
                end
            end
            SPACE: begin
                // Letter gap fires even if a new mark is seen on this same cycle.
                if (cnt_inc == LGAP && sym_cnt_q != 3'd0) begin
                    sym_d     = 4'd0;
                    sym_cnt_d = 3'd0;
                    ovf_d     = 1'b0;
                    if (ovf_q || !dec[5]) begin
                        err_d = 1'b1;
                    end else begin
                        char_valid_d = 1'b1;
                        char_out_d   = dec[4:0];
                        seen_d       = 1'b1;
                    end
                end
                if (s2_q) begin
                    state_d = MARK;
                    cnt_d   = ONE;
                end else if (cnt_inc == WGAP) begin
                    state_d = IDLE;
                    if (seen_q) begin
                        char_valid_d = 1'b1;
                        char_out_d   = 5'd0;
                        seen_d       = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q         <= 1'b0;
            s2_q         <= 1'b0;
            state_q      <= IDLE;
            cnt_q        <= '0;
            sym_q        <= 4'd0;
            sym_cnt_q    <= 3'd0;
            ovf_q        <= 1'b0;
            seen_q       <= 1'b0;
            char_out_q   <= 5'd0;
            char_valid_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            s1_q         <= din;
            s2_q         <= s1_q;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sym_q        <= sym_d;
            sym_cnt_q    <= sym_cnt_d;
            ovf_q        <= ovf_d;
            seen_q       <= seen_d;
            char_out_q   <= char_out_d;
            char_valid_q <= char_valid_d;
            err_q        <= err_d;
        end
    end

    assign char_out   = char_out_q;
    assign char_valid = char_valid_q;
    assign err        = err_q;
    assign busy       = sym_cnt_q != 3'd0;
endmodule

// File: tb/tb_morse_rx_decoder.sv
// tb_morse_rx_decoder: directed Morse sequences with a strobe scoreboard checking code, kind and latency.
module tb_morse_rx_decoder;
    localparam int TU = 10;

    typedef struct {
        bit         is_char;
        logic [4:0] code;
        int         at;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       din = 1'b0;
    logic [4:0] char_out;
    logic       char_valid;
    logic       err;
    logic       busy;
    int         cyc = 0;
    int         n_assert = 0;
    int         n_fail = 0;
    int         tf;
    logic [4:0] last_code = 5'd0;
    exp_t       exp_q[$];

    morse_rx_decoder #(.TIME_UNIT(TU), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .din(din),
        .char_out(char_out), .char_valid(char_valid), .err(err), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic drive(input logic v, input int n);
        din = v;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_char(input logic [4:0] code, input int at);
        exp_q.push_back('{1'b1, code, at});
        last_code = code;
    endtask

    task automatic push_err(input int at);
        exp_q.push_back('{1'b0, last_code, at});
    endtask

    always @(negedge clk) begin
        if (!rst && (char_valid || err)) begin
            check("exclusive", {31'd0, char_valid & err}, 0);
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", {30'd0, char_valid, err}, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("strobe_kind", {31'd0, char_valid}, {31'd0, e.is_char});
                check("char_out", {27'd0, char_out}, {27'd0, e.code});
                check("latency", cyc, e.at);
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_char_out", {27'd0, char_out}, 0);
        check("rst_char_valid", {31'd0, char_valid}, 0);
        check("rst_err", {31'd0, err}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        rst = 1'b0;
        drive(0, 5);
        // A: .- then a word gap
        drive(1, 10);
        drive(0, 10);
        check("busy_after_dot", {31'd0, busy}, 1);
        drive(1, 30);
        tf = cyc;
        push_char(5'd1, tf + 22);
        push_char(5'd0, tf + 52);
        drive(0, 60);
        check("busy_idle_a", {31'd0, busy}, 0);
        check("pending_a", exp_q.size(), 0);
        // E then T
        drive(1, 10);
        tf = cyc;
        push_char(5'd5, tf + 22);
        drive(0, 30);
        drive(1, 30);
        tf = cyc;
        push_char(5'd20, tf + 22);
        push_char(5'd0, tf + 52);
        drive(0, 70);
        check("pending_et", exp_q.size(), 0);
        // Glitch inside the space after .- restarts the space but adds no symbol
        drive(1, 10);
        drive(0, 10);
        drive(1, 30);
        drive(0, 8);
        drive(1, 3);
        tf = cyc;
        push_char(5'd1, tf + 22);
        push_char(5'd0, tf + 52);
        drive(0, 70);
        check("pending_glitch", exp_q.size(), 0);
        // E, then five dots overflow: err keeps char_out at 5, word space still follows
        drive(1, 10);
        tf = cyc;
        push_char(5'd5, tf + 22);
        drive(0, 30);
        for (int i = 0; i < 5; i++) begin
            drive(1, 10);
            if (i < 4) drive(0, 10);
        end
        tf = cyc;
        push_err(tf + 22);
        push_char(5'd0, tf + 52);
        drive(0, 25);
        check("busy_after_ovf", {31'd0, busy}, 0);
        drive(0, 45);
        check("pending_ovf", exp_q.size(), 0);
        // Unassigned ..-- then no word space
        drive(1, 10); drive(0, 10);
        drive(1, 10); drive(0, 10);
        drive(1, 30); drive(0, 10);
        drive(1, 30);
        tf = cyc;
        push_err(tf + 22);
        drive(0, 70);
        check("pending_unassigned", exp_q.size(), 0);
        // Mark of exactly 2*TU is a dash, 2*TU-1 is a dot
        drive(1, 20);
        tf = cyc;
        push_char(5'd20, tf + 22);
        drive(0, 30);
        drive(1, 19);
        tf = cyc;
        push_char(5'd5, tf + 22);
        push_char(5'd0, tf + 52);
        drive(0, 60);
        check("pending_mark_len", exp_q.size(), 0);
        // Space exactly 2*TU decodes E before the next dash
        drive(1, 10);
        tf = cyc;
        push_char(5'd5, tf + 22);
        drive(0, 20);
        drive(1, 30);
        tf = cyc;
        push_char(5'd20, tf + 22);
        push_char(5'd0, tf + 52);
        drive(0, 60);
        // Space 19: new mark arrives the cycle the gap is reached; decode still fires
        drive(1, 10);
        tf = cyc;
        push_char(5'd5, tf + 22);
        drive(0, 19);
        drive(1, 30);
        tf = cyc;
        push_char(5'd20, tf + 22);
        push_char(5'd0, tf + 52);
        drive(0, 60);
        // Space 18: no gap, so .- is A
        drive(1, 10);
        drive(0, 18);
        drive(1, 30);
        tf = cyc;
        push_char(5'd1, tf + 22);
        push_char(5'd0, tf + 52);
        drive(0, 60);
        check("pending_space_len", exp_q.size(), 0);
        // Saturating long mark is still a dash
        drive(1, 80);
        tf = cyc;
        push_char(5'd20, tf + 22);
        push_char(5'd0, tf + 52);
        drive(0, 80);
        check("pending_sat", exp_q.size(), 0);
        // Reset mid-letter after E was shown
        drive(1, 10);
        tf = cyc;
        push_char(5'd5, tf + 22);
        drive(0, 30);
        drive(1, 10); drive(0, 10);
        drive(1, 10); drive(0, 5);
        check("busy_mid_letter", {31'd0, busy}, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        last_code = 5'd0;
        check("rst_mid_char_out", {27'd0, char_out}, 0);
        check("rst_mid_busy", {31'd0, busy}, 0);
        check("rst_mid_valid", {31'd0, char_valid}, 0);
        check("rst_mid_err", {31'd0, err}, 0);
        drive(0, 80);
        check("pending_rst", exp_q.size(), 0);
        check("final_char_out", {27'd0, char_out}, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
